multi_dice_roller: RTL



---
 rtl/dice_pkg.sv | 33 +++
 rtl/lfsr_gen.sv | 30 +++
 rtl/multi_dice_roller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared constants for the multi-channel dice roller: mode encodings,
// Galois LFSR tap masks, the per-channel seed scramble and a clog2 helper.
package dice_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_SHOW_CH  = 2'd1,
        MODE_SHOW_SUM = 2'd2
    } mode_e;

    // Right-shifting Galois masks for maximal-length polynomials.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] SEED_SCRAMBLE = 16'h9E37;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return {24'h0, LFSR_TAPS_8};
            16:      return {16'h0, LFSR_TAPS_16};
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR; reloads its seed on reset and never sits at zero.
module lfsr_gen
    import dice_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q >> 1;
        if (value_q[0]) value_d = (value_q >> 1) ^ TAPS;
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= INIT;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/multi_dice_roller.sv
// NUM_CH dice channels with per-channel roll buttons, a sum view and clear;
// a mode FSM selects what the registered LED bus shows.
module multi_dice_roller
    import dice_pkg::*;
#(
    parameter int          NUM_CH  = 2,
    parameter int          RAND_W  = 5,
    parameter int          MAX_VAL = 6,
    parameter int          LFSR_W  = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         SUM_W   = RAND_W + clog2(NUM_CH),
    localparam int         CH_W    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_roll,
    input  logic              btn_sum,
    input  logic              btn_clear,
    output logic [SUM_W-1:0]  led,
    output logic [1:0]        mode,
    output logic [CH_W-1:0]   cur_ch,
    output logic [NUM_CH-1:0] rolled,
    output logic              roll_evt
);

    logic [LFSR_W-1:0] lfsr [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [31:0] RAW = 32'(SEED) ^ (32'(k + 1) * 32'(SEED_SCRAMBLE));
        localparam logic [LFSR_W-1:0] CH_SEED =
            (RAW[LFSR_W-1:0] == '0) ? LFSR_W'(1) : RAW[LFSR_W-1:0];
        lfsr_gen #(.LFSR_W(LFSR_W), .SEED(CH_SEED)) u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .value (lfsr[k])
        );
    end

    logic [NUM_CH-1:0] roll_q;
    logic              sum_q, clear_q;
    logic [NUM_CH-1:0] roll_ev;
    logic              sum_ev, clear_ev;

    assign roll_ev  = btn_roll & ~roll_q;
    assign sum_ev   = btn_sum & ~sum_q;
    assign clear_ev = btn_clear & ~clear_q;

    logic            roll_hit;
    logic [CH_W-1:0] roll_idx;

    // Descending scan so the lowest-numbered requesting channel wins.
    always_comb begin
        roll_hit = 1'b0;
        roll_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (roll_ev[i]) begin
                roll_hit = 1'b1;
                roll_idx = CH_W'(i);
            end
        end
    end

    logic [LFSR_W-1:0] sel_lfsr;
    logic [RAND_W-1:0] roll_val;
    logic              lfsr_unused;

    assign sel_lfsr    = lfsr[roll_idx];
    assign roll_val    = RAND_W'((32'(sel_lfsr[RAND_W-1:0]) % MAX_VAL) + 1);
    assign lfsr_unused = ^sel_lfsr[LFSR_W-1:RAND_W];

    mode_e mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (rst) mode_q <= MODE_IDLE;
        else     mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (clear_ev)      mode_d = MODE_IDLE;
        else if (roll_hit) mode_d = MODE_SHOW_CH;
        else if (sum_ev)   mode_d = MODE_SHOW_SUM;
    end

    logic [RAND_W-1:0] hold_q [NUM_CH];
    logic [RAND_W-1:0] hold_d [NUM_CH];
    logic [NUM_CH-1:0] rolled_q, rolled_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              evt_q, evt_d;
    logic [SUM_W-1:0]  led_q, led_d;
    logic [SUM_W-1:0]  sum_w;

    always_comb begin
        hold_d   = hold_q;
        rolled_d = rolled_q;
        cur_ch_d = cur_ch_q;
        evt_d    = 1'b0;
        if (clear_ev) begin
            hold_d   = '{default: '0};
            rolled_d = '0;
            cur_ch_d = '0;
        end else if (roll_hit) begin
            hold_d[roll_idx]   = roll_val;
            rolled_d[roll_idx] = 1'b1;
            cur_ch_d           = roll_idx;
            evt_d              = 1'b1;
        end
    end

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < NUM_CH; i++) sum_w = sum_w + SUM_W'(hold_q[i]);
    end

    // LED follows the registered state, so it lags an event by one edge.
    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_SHOW_CH:  led_d = SUM_W'(hold_q[cur_ch_q]);
            MODE_SHOW_SUM: led_d = sum_w;
            default:       led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            roll_q   <= '0;
            sum_q    <= 1'b0;
            clear_q  <= 1'b0;
            hold_q   <= '{default: '0};
            rolled_q <= '0;
            cur_ch_q <= '0;
            evt_q    <= 1'b0;
            led_q    <= '0;
        end else begin
            roll_q   <= btn_roll;
            sum_q    <= btn_sum;
            clear_q  <= btn_clear;
            hold_q   <= hold_d;
            rolled_q <= rolled_d;
            cur_ch_q <= cur_ch_d;
            evt_q    <= evt_d;
            led_q    <= led_d;
        end
    end

    assign led      = led_q;
    assign mode     = mode_q;
    assign cur_ch   = cur_ch_q;
    assign rolled   = rolled_q;
    assign roll_evt = evt_q;

endmodule
